// File: rtl/systolic_feed_sequencer.sv
// Compute-phase sequencer: pops K_DEPTH operand vectors, drives skewed
// row/column valid strobes, drains the array and pulses compute_done.
module systolic_feed_sequencer #(
    parameter int ARRAY_SIZE = 2,
    parameter int K_DEPTH    = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  compute_start,
    input  logic                  rempty,
    output logic                  fifo_rd_en,
    output logic [ARRAY_SIZE-1:0] row_valid,
    output logic [ARRAY_SIZE-1:0] col_valid,
    output logic                  acc_clear,
    output logic                  busy,
    output logic                  compute_done
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  start_q;
    logic [CNT_W-1:0]      feed_cnt_q, feed_cnt_d;
    logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [ARRAY_SIZE-1:0] skew_q, skew_d;
    logic                  acc_clear_q, acc_clear_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  abort;

    assign fifo_rd_en = (state_q == FEED) && !rempty &&
                        (feed_cnt_q < CNT_W'(K_DEPTH));

    assign abort = ((state_q == FEED) || (state_q == DRAIN)) && !compute_start;

    always_comb begin
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        acc_clear_d = 1'b0;
        skew_d      = '0;
        skew_d[0]   = fifo_rd_en;
        for (int i = 1; i < ARRAY_SIZE; i++) begin
            skew_d[i] = skew_q[i-1];
        end

        if (abort) begin
            state_d     = IDLE;
            feed_cnt_d  = '0;
            drain_cnt_d = '0;
            skew_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (compute_start && !start_q) begin
                        state_d     = FEED;
                        feed_cnt_d  = '0;
                        drain_cnt_d = '0;
                        acc_clear_d = 1'b1;
                    end
                end
                FEED: begin
                    if (fifo_rd_en) begin
                        feed_cnt_d = feed_cnt_q + 1'b1;
                        if (feed_cnt_q == CNT_W'(K_DEPTH - 1)) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                end
                DRAIN: begin
                    // Drain long enough for the last vector to cross the skew
                    if (drain_cnt_q == CNT_W'(2 * ARRAY_SIZE - 1)) begin
                        state_d     = DONE;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    feed_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            skew_q      <= '0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= compute_start;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            skew_q      <= skew_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign row_valid    = skew_q;
    assign col_valid    = skew_q;
    assign acc_clear    = acc_clear_q;
    assign busy         = busy_q;
    assign compute_done = done_q;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Directed bench: N=2/K=4 instance (a) and N=1/K=1 instance (b).
// Expected per-cycle values are bit masks, bit c = value in cycle c.
module tb_systolic_feed_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, rempty;
    logic       rd_a, acc_a, busy_a, done_a;
    logic [1:0] rv_a, cv_a;
    logic       rd_b, acc_b, busy_b, done_b;
    logic [0:0] rv_b, cv_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    systolic_feed_sequencer #(
        .ARRAY_SIZE(2), .K_DEPTH(4), .CNT_W(8)
    ) u_a (
        .clk(clk), .rst(rst), .compute_start(start_a), .rempty(rempty),
        .fifo_rd_en(rd_a), .row_valid(rv_a), .col_valid(cv_a),
        .acc_clear(acc_a), .busy(busy_a), .compute_done(done_a)
    );

    systolic_feed_sequencer #(
        .ARRAY_SIZE(1), .K_DEPTH(1), .CNT_W(8)
    ) u_b (
        .clk(clk), .rst(rst), .compute_start(start_b), .rempty(rempty),
        .fifo_rd_en(rd_b), .row_valid(rv_b), .col_valid(cv_b),
        .acc_clear(acc_b), .busy(busy_b), .compute_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run(input string name, input bit sel, input int ncyc,
                       input int drop, input logic [31:0] emp,
                       input logic [31:0] e_rd, input logic [31:0] e_acc,
                       input logic [31:0] e_rv0, input logic [31:0] e_rv1,
                       input logic [31:0] e_done, input logic [31:0] e_busy);
        logic [1:0] rv, cv, erv;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (sel) start_b = (c < drop);
            else     start_a = (c < drop);
            rempty = emp[c];
            #2;
            rv  = sel ? {1'b0, rv_b} : rv_a;
            cv  = sel ? {1'b0, cv_b} : cv_a;
            erv = {e_rv1[c], e_rv0[c]};
            check($sformatf("%s c%0d rd", name, c),
                  32'(sel ? rd_b : rd_a), 32'(e_rd[c]));
            check($sformatf("%s c%0d acc", name, c),
                  32'(sel ? acc_b : acc_a), 32'(e_acc[c]));
            check($sformatf("%s c%0d row", name, c), 32'(rv), 32'(erv));
            check($sformatf("%s c%0d col", name, c), 32'(cv), 32'(erv));
            check($sformatf("%s c%0d done", name, c),
                  32'(sel ? done_b : done_a), 32'(e_done[c]));
            check($sformatf("%s c%0d busy", name, c),
                  32'(sel ? busy_b : busy_a), 32'(e_busy[c]));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            rempty  = 1'b0;
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " rd"},   32'({rd_a, rd_b}), 32'd0);
        check({name, " acc"},  32'({acc_a, acc_b}), 32'd0);
        check({name, " row"},  32'({rv_a, rv_b}), 32'd0);
        check({name, " col"},  32'({cv_a, cv_b}), 32'd0);
        check({name, " done"}, 32'({done_a, done_b}), 32'd0);
        check({name, " busy"}, 32'({busy_a, busy_b}), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        rempty  = 1'b0;
        #12;
        check_zero("reset");
        #3 rst = 1'b1;
        idle(2);

        // nominal: pops 1-4, row0 2-5, row1 3-6, done 9
        run("t2", 0, 12, 12, 32'h0, 32'h1E, 32'h2, 32'h3C, 32'h78,
            32'h200, 32'h3FE);
        idle(3);

        // stall in cycles 2-3: pops 1,4,5,6, done 11
        run("t3", 0, 14, 14, 32'hC, 32'h72, 32'h2, 32'hE4, 32'h1C8,
            32'h800, 32'hFFE);
        idle(3);

        // abort: start low in cycle 3
        run("t4", 0, 12, 3, 32'h0, 32'hE, 32'h2, 32'hC, 32'h8,
            32'h0, 32'hE);
        idle(3);

        // level held 5 cycles past done: no restart
        run("t5", 0, 15, 15, 32'h0, 32'h1E, 32'h2, 32'h3C, 32'h78,
            32'h200, 32'h3FE);
        idle(3);

        // N=1, K=1 back-to-back tiles
        run("t6a", 1, 5, 4, 32'h0, 32'h2, 32'h2, 32'h4, 32'h0,
            32'h10, 32'h1E);
        run("t6b", 1, 6, 4, 32'h0, 32'h2, 32'h2, 32'h4, 32'h0,
            32'h10, 32'h1E);
        idle(3);

        // async reset in the middle of FEED
        run("t1", 0, 3, 3, 32'h0, 32'h6, 32'h2, 32'h4, 32'h0,
            32'h0, 32'h6);
        #1 rst = 1'b0;
        #1 check_zero("t1 async");
        start_a = 1'b0;
        #1 rst = 1'b1;
        run("t1post", 0, 12, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
